// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: error-responder FSM states and the DECERR response code.
package axi_node_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RESP    = 2'd2
  } err_state_e;

  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_ar_error_responder_if.sv
// R-channel bundle between the error responder (master) and the initiator-side R mux (slave).
interface axi_ar_error_responder_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 6
);

  logic                  rvalid_o;
  logic                  rready_i;
  logic [ID_WIDTH-1:0]   rid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic [1:0]            rresp_o;
  logic                  rlast_o;
  logic [USER_WIDTH-1:0] ruser_o;

  modport master (
    output rvalid_o, rid_o, rdata_o, rresp_o, rlast_o, ruser_o,
    input  rready_i
  );

  modport slave (
    input  rvalid_o, rid_o, rdata_o, rresp_o, rlast_o, ruser_o,
    output rready_i
  );

endinterface

// File: rtl/axi_ar_error_responder.sv
// Answers a decode-error read with arlen+1 DECERR beats once the port's earlier reads have drained.
module axi_ar_error_responder
  import axi_node_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_ardata_info_i,
  input  logic [ID_WIDTH-1:0] arid_i,
  input  logic [7:0]          arlen_i,
  input  logic                outstanding_trans_i,
  output logic                error_gnt_o,
  axi_ar_error_responder_if.master r_bus
);

  err_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;

  // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    rid_d       = rid_q;
    cnt_d       = cnt_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    error_gnt_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The counter doubles as the captured length: it starts at arlen and counts down.
        if (sample_ardata_info_i) begin
          rid_d   = arid_i;
          cnt_d   = arlen_i;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!outstanding_trans_i) begin
          error_gnt_o = 1'b1;
          state_d     = ST_RESP;
          rvalid_d    = 1'b1;
          rlast_d     = (cnt_q == 8'd0);
        end
      end
      ST_RESP: begin
        if (r_bus.rready_i) begin
          if (cnt_q == 8'd0) begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            rlast_d = (cnt_q == 8'd1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rid_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rid_q    <= rid_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
    end
  end

  // Payload comes straight from flops, so it cannot move while a beat is stalled.
  assign r_bus.rvalid_o = rvalid_q;
  assign r_bus.rlast_o  = rlast_q;
  assign r_bus.rid_o    = rid_q;
  assign r_bus.rresp_o  = rvalid_q ? RESP_DECERR : 2'b00;
  assign r_bus.rdata_o  = '0;
  assign r_bus.ruser_o  = '0;

endmodule

// File: tb/tb_axi_ar_error_responder.sv
// Self-checking bench: table-driven and random decode-error bursts against a beat-counting model.
module tb_axi_ar_error_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample;
  logic [3:0] arid;
  logic [7:0] arlen;
  logic       outstanding;
  logic       gnt;

  int total = 0;
  int bad   = 0;

  axi_ar_error_responder_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .USER_WIDTH(6)) rb ();

  axi_ar_error_responder #(.ID_WIDTH(4), .DATA_WIDTH(64), .USER_WIDTH(6)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .sample_ardata_info_i (sample),
    .arid_i               (arid),
    .arlen_i              (arlen),
    .outstanding_trans_i  (outstanding),
    .error_gnt_o          (gnt),
    .r_bus                (rb.master)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] id;
    int         len;
    int         pend;   // cycles outstanding_trans_i stays high
    int         mode;   // rready: 0 = always 1, 1 = toggle 1,0,..., 2 = random
    bit         glitch; // extra sample pulse during the first RESP cycle
  } vec_t;

  // Bit layout: gnt[78] rvalid[77] rlast[76] rid[75:72] rresp[71:70] rdata[69:6] ruser[5:0]
  function automatic logic [127:0] pack_out();
    return {49'd0, gnt, rb.rvalid_o, rb.rlast_o, rb.rid_o, rb.rresp_o, rb.rdata_o, rb.ruser_o};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload fields are only meaningful while a beat is offered, so they are masked otherwise.
  task automatic cmp(input string name, input logic e_gnt, input logic e_vld,
                     input logic e_lst, input logic [3:0] e_id);
    logic [127:0] act, exp;
    @(negedge clk);
    act = pack_out();
    exp = {49'd0, e_gnt, e_vld, e_lst, e_id, 2'b11, 64'd0, 6'd0};
    if (!e_vld) begin
      act[75:0] = '0;
      exp[75:0] = '0;
    end
    check(name, act, exp);
  endtask

  task automatic cmp_all_zero(input string name);
    @(negedge clk);
    check(name, pack_out(), 128'd0);
  endtask

  // Model: a request produces exactly len+1 beats after its grant; the last offered beat has rlast.
  task automatic run_burst(input vec_t v);
    int remaining;
    int guard;
    int budget;
    logic rdy;
    remaining = v.len + 1;
    budget    = 8 * (v.len + 1) + 20;

    tick();
    sample = 1'b1; arid = v.id; arlen = 8'(v.len);
    outstanding = 1'($urandom_range(1)); rb.rready_i = 1'($urandom_range(1));
    cmp("capture", 1'b0, 1'b0, 1'b0, v.id);

    for (int p = 0; p < v.pend; p++) begin
      tick();
      sample = 1'b0; outstanding = 1'b1; rb.rready_i = 1'($urandom_range(1));
      cmp("pending", 1'b0, 1'b0, 1'b0, v.id);
    end

    tick();
    sample = 1'b0; outstanding = 1'b0;
    cmp("grant", 1'b1, 1'b0, 1'b0, v.id);

    guard = 0;
    while (remaining > 0 && guard < budget) begin
      tick();
      case (v.mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2 == 0);
        default: rdy = 1'($urandom_range(1));
      endcase
      rb.rready_i = rdy;
      outstanding = 1'($urandom_range(1));
      sample = v.glitch && (guard == 0);
      arid   = ~v.id;
      arlen  = 8'(v.len) ^ 8'h5a;
      if (sample) $display("note: protocol violation injected (ardata sample outside IDLE)");
      cmp("beat", 1'b0, 1'b1, remaining == 1, v.id);
      if (rdy) remaining--;
      guard++;
    end
    check("beats_left", 128'(remaining), 128'd0);

    tick();
    sample = 1'b0; outstanding = 1'b0; rb.rready_i = 1'($urandom_range(1));
    cmp("idle_after", 1'b0, 1'b0, 1'b0, v.id);
  endtask

  vec_t vecs[6];

  initial begin
    vec_t rv;

    vecs[0] = '{id: 4'd5,  len: 0,   pend: 0,  mode: 0, glitch: 1'b0};
    vecs[1] = '{id: 4'd3,  len: 3,   pend: 0,  mode: 1, glitch: 1'b0};
    vecs[2] = '{id: 4'ha,  len: 2,   pend: 10, mode: 0, glitch: 1'b0};
    vecs[3] = '{id: 4'hf,  len: 255, pend: 0,  mode: 0, glitch: 1'b0};
    vecs[4] = '{id: 4'd6,  len: 4,   pend: 2,  mode: 2, glitch: 1'b1};
    vecs[5] = '{id: 4'd1,  len: 1,   pend: 1,  mode: 1, glitch: 1'b1};

    rst = 1'b1; sample = 1'b0; arid = '0; arlen = '0; outstanding = 1'b0; rb.rready_i = 1'b0;
    tick();
    cmp_all_zero("reset_state");
    tick();
    rst = 1'b0;
    cmp_all_zero("after_reset_idle");

    foreach (vecs[i]) run_burst(vecs[i]);

    // Reset in the middle of an arlen=7 burst, then a fresh single-beat request.
    tick();
    sample = 1'b1; arid = 4'd2; arlen = 8'd7; outstanding = 1'b0; rb.rready_i = 1'b1;
    cmp("mid_capture", 1'b0, 1'b0, 1'b0, 4'd2);
    tick();
    sample = 1'b0;
    cmp("mid_grant", 1'b1, 1'b0, 1'b0, 4'd2);
    for (int b = 0; b < 2; b++) begin
      tick();
      cmp("mid_beat", 1'b0, 1'b1, 1'b0, 4'd2);
    end
    tick();
    rst = 1'b1; rb.rready_i = 1'b0;
    cmp("mid_beat_at_rst", 1'b0, 1'b1, 1'b0, 4'd2);
    tick();
    rst = 1'b0;
    cmp_all_zero("mid_after_rst");
    run_burst('{id: 4'd9, len: 0, pend: 0, mode: 0, glitch: 1'b0});

    for (int n = 0; n < 20; n++) begin
      rv.id     = 4'($urandom);
      rv.len    = int'($urandom_range(20));
      rv.pend   = int'($urandom_range(5));
      rv.mode   = 2;
      rv.glitch = 1'($urandom_range(1));
      run_burst(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_ar_error_responder.md
AXI_AR_ERROR_RESPONDER -- requirements
Module: axi_ar_error_responder

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4: width of the AXI ID field.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: width of the R data bus.
REQ-003 SHALL have parameter USER_WIDTH, default 6: width of the R user field.
REQ-004 SHALL have port clk  in  1: single clock for the block.
REQ-005 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port sample_ardata_info_i  in  1: pulse from the AR address decoder; a decode-error request was accepted.
REQ-007 SHALL have port arid_i  in  ID_WIDTH: ARID of the erroneous request, valid when sample_ardata_info_i=1.
REQ-008 SHALL have port arlen_i  in  8: ARLEN of the erroneous request, valid when sample_ardata_info_i=1.
REQ-009 SHALL have port outstanding_trans_i  in  1: 1 = read transactions from this slave port are still in flight.
REQ-010 SHALL have port error_gnt_o  out  1: grant back to the decoder; releases its ERROR stall.
REQ-011 SHALL have ports rvalid_o out 1, rready_i in 1: R-channel handshake toward the initiator-side R mux.
REQ-012 SHALL have ports rid_o out ID_WIDTH, rdata_o out DATA_WIDTH, rresp_o out 2, rlast_o out 1, ruser_o out USER_WIDTH: R payload.

Function
REQ-013 SHALL implement states IDLE, PENDING and RESP.
REQ-014 In IDLE, sample_ardata_info_i=1 SHALL capture arid_i and arlen_i, load the beat counter with arlen_i, and enter PENDING on the next cycle.
REQ-015 In PENDING with outstanding_trans_i=1, the block SHALL stay in PENDING with error_gnt_o=0 and rvalid_o=0.
REQ-016 In PENDING with outstanding_trans_i=0, error_gnt_o SHALL be 1 combinationally for exactly that cycle, and the block SHALL enter RESP on the next cycle.
REQ-017 error_gnt_o SHALL be 0 in every state and condition other than REQ-016.
REQ-018 In RESP, rvalid_o SHALL be 1 with the following payload:
- rid_o = captured ID
- rresp_o = 2'b11 (DECERR)
- rdata_o = 0
- ruser_o = 0
REQ-019 rlast_o SHALL be 1 exactly when in RESP and the beat counter equals 0.
REQ-020 On rvalid_o&rready_i with counter>0, the counter SHALL decrement by 1.
REQ-021 On rvalid_o&rready_i with counter=0, the block SHALL return to IDLE on the next cycle with rvalid_o=0.
REQ-022 The beat count SHALL be exactly arlen+1, for arlen 0..255; the 8-bit counter SHALL never wrap.
REQ-023 While rready_i=0, all R outputs SHALL hold stable (AXI rule: valid never drops without a handshake).
REQ-024 rvalid_o SHALL not depend combinationally on rready_i.
REQ-025 sample_ardata_info_i asserted outside IDLE SHALL be ignored, leaving the captured fields unchanged; the bench flags this as a protocol violation.
REQ-026 The first R beat SHALL appear no earlier than the cycle after the error_gnt_o cycle.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE and clear the counter, captured ID and captured length, including in the middle of a burst.
REQ-028 During and after reset, outputs SHALL be: rvalid_o=0, rlast_o=0, error_gnt_o=0, rid_o=0, rdata_o=0, rresp_o=0, ruser_o=0.

Structure
REQ-029 The state enum and the RESP_DECERR=2'b11 constant SHALL live in the shared axi_node package.
REQ-030 No sub-module: the block SHALL be one FSM plus a counter/capture register file.

Verification
REQ-031 arlen=0, id=5, outstanding=0, rready=1 -> error_gnt one cycle after capture; next cycle one beat: rid=5, rresp=3, rlast=1; then IDLE.
REQ-032 arlen=3, rready toggling 1,0,1,0,... -> 4 beats, rlast only on the 4th, and payload stable through every rready=0 cycle.
REQ-033 arlen=2, outstanding held 1 for 10 cycles then 0 -> no gnt and no rvalid for those 10 cycles; gnt in the cycle outstanding falls; 3 beats follow.
REQ-034 arlen=255, rready=1 -> exactly 256 beats, rlast only on the last, no counter wrap.
REQ-035 rst=1 after beat 2 of an arlen=7 burst -> next cycle rvalid=0 and state IDLE; a new capture with id=9, arlen=0 then completes normally.
REQ-036 Second sample_ardata_info_i pulse during RESP -> ignored; the original ID and beat count complete unchanged.
